// File: rtl/pri_enco_arb.sv
// Registered N-way arbiter with fixed-priority or round-robin selection.
// Holds the granted index and its one-hot grant under a valid/ready handshake.
module pri_enco_arb #(
  parameter  int N    = 8,
  parameter  int MODE = 0,
  localparam int W    = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic [W-1:0] o,
  output logic         v,
  output logic [N-1:0] grant,
  output logic         multi
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   o_q, o_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           multi_q, multi_d;
  logic [W-1:0]   ptr_q, ptr_d;

  logic           xfer;
  logic           any_req;
  logic           win_found;
  logic [W-1:0]   win_idx;

  assign xfer    = (state_q == HOLD) && ready;
  assign any_req = |req;

  // A completed transfer moves the search start just below the index that was taken.
  always_comb begin
    ptr_d = ptr_q;
    if (en && xfer && (MODE == 1)) begin
      ptr_d = (o_q == '0) ? W'(N - 1) : o_q - W'(1);
    end
  end

  // Scan ptr, ptr-1, ..., wrapping modulo N; back-to-back reloads see the updated pointer.
  always_comb begin
    int cand;
    logic [W-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr_d) - i;
      if (cand < 0) begin
        cand = cand + N;
      end
      cand_idx = W'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    grant_d = grant_q;
    multi_d = multi_q;
    if (!en) begin
      state_d = IDLE;
      o_d     = '0;
      grant_d = '0;
      multi_d = 1'b0;
    end else if ((state_q == IDLE) || xfer) begin
      if (any_req && win_found) begin
        state_d = HOLD;
        o_d     = win_idx;
        grant_d = N'(1) << win_idx;
        multi_d = (req & (req - N'(1))) != '0;
      end else begin
        state_d = IDLE;
        o_d     = '0;
        grant_d = '0;
        multi_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      o_q     <= '0;
      grant_q <= '0;
      multi_q <= 1'b0;
      ptr_q   <= W'(N - 1);
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      grant_q <= grant_d;
      multi_q <= multi_d;
      ptr_q   <= ptr_d;
    end
  end

  assign v     = (state_q == HOLD);
  assign o     = o_q;
  assign grant = grant_q;
  assign multi = multi_q;

endmodule

// File: doc/pri_enco_arb.md
# pri_enco_arb

Parametrised, registered successor to the 8-to-3 priority encoder. It accepts an N-bit request vector and selects one requester, either by fixed priority (highest index wins) or by round-robin. The selected index and its one-hot grant are held in an output register under a valid/ready handshake. It sits between request sources and a single shared downstream consumer, and supplies one accepted index per cycle at full throughput.

## Interface
- N, default 8: number of request inputs, ≥ 2.
- MODE, default 0: 0 = fixed priority (index N-1 highest); 1 = round-robin.
- W (localparam): $clog2(N), the width of the index output.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- en  input  1  enable; when low, the block clears and ignores requests.
- req  input  N  request vector; bit i is requester i.
- ready  input  1  downstream accepts the current output this cycle.
- o  output  W  encoded index of the granted requester.
- v  output  1  valid; o, grant and multi are meaningful while v is high.
- grant  output  N  one-hot of o; all zeros when v is low.
- multi  output  1  more than one req bit was set when the current o was loaded.

## Operation
- State is an FSM with two states:
  - IDLE: v = 0.
  - HOLD: v = 1.
- A search pointer ptr, W bits, gives the highest-priority index.
  - Search order is ptr, ptr-1, …, 0, N-1, …, ptr+1, with modulo-N wrap.
  - The first set req bit in that order wins.
- MODE = 0: ptr is fixed at N-1, which gives pure fixed priority and matches the 8-to-3 encoder.
- MODE = 1: on every accepted transfer (v && ready) of index k, ptr ← k-1 mod N. For k = 0, ptr ← N-1.
- IDLE transitions:
  - If en && |req: load o, grant and multi from the current req, then go to HOLD.
  - Otherwise stay in IDLE with o = 0, grant = 0, multi = 0.
- HOLD with ready = 0: o, grant and multi stay frozen, whatever req does. Changes to req, including deassertion of the granted bit, are ignored.
- HOLD with ready = 1:
  - The transfer completes and ptr updates.
  - If en && |req in the same cycle, reload immediately (back-to-back) and stay in HOLD.
  - A back-to-back reload arbitrates with the updated ptr and the current req.
  - Otherwise go to IDLE.
- en = 0 in any state, sampled at the edge:
  - Next state is IDLE.
  - v, o, grant and multi clear to 0.
  - ptr is unchanged.
  - The pending transfer is dropped, not counted, and causes no ptr update.
- multi = 1 when popcount(req) ≥ 2 at the load edge.
- Unused index codes (N not a power of 2) are never produced.

## Timing
- Reset is asynchronous: while rst_n = 0, v = 0, o = 0, grant = 0, multi = 0, state = IDLE and ptr = N-1. This applies immediately, including mid-HOLD.
- The first edge after rst_n rises behaves as normal operation.
- Latency: req sampled at edge t appears on o/v after edge t, i.e. one cycle.
- Throughput: one grant per cycle while ready = 1 and requests persist.
- ready is a don't-care while v = 0.
- All outputs come directly from registers. There is no combinational path from req, en or ready to any output.

## Test plan
- **Reset:**
  - Stimulus: pulse rst_n low asynchronously while v = 1, o = 5.
  - Response: v, o, grant and multi go to 0 without a clock edge.
  - Then, with MODE = 1, req = 8'hFF and ready = 1, the first grant is o = 7.
- **Fixed-priority walk (N = 8, MODE = 0, en = 1, ready = 1):**
  - Stimulus: req = 8'b10000000, 01000000, …, 00000001, then 00000000.
  - Response: o = 7, 6, …, 0, each one cycle later, with v = 1 and grant equal to req. The final all-zero req gives v = 0.
- **Enable and multi:**
  - en = 0 with req = 8'hFF gives v = 0.
  - en = 1 with req = 8'b00100110 gives o = 5, grant = 8'b00100000, multi = 1.
- **Backpressure:**
  - Stimulus: ready = 0, v = 1, o = 5; change req to 8'h80.
  - Response: o stays 5 for all stalled cycles. One cycle after ready = 1, o = 7.
  - Dropping en during the stall gives v = 0 next cycle.
- **Round-robin rotation (MODE = 1, req = 8'hFF held, ready = 1):**
  - Response: o = 7, 6, 5, 4, 3, 2, 1, 0, 7, … with no gap cycles and grant one-hot throughout.
- **Round-robin wrap and fairness:**
  - Stimulus: req = 8'b00000011 held, ready = 1.
  - Response: o alternates 1, 0, 1, 0.
  - After a grant of 0, ptr = 7; a new req = 8'b10000001 then gives o = 7.
